// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// Memory stage of the 24-bit pipelined core. It sits right after execute, owns
// the word-addressed data RAM, performs loads and stores, and registers the
// write-back bundle for the write-back stage. The hazard unit can hold the
// stage (stall) or replace the incoming instruction with a bubble (flush).
//
// Ports
//   clk              core clock, all state changes on the rising edge
//   reset            synchronous, active-high; highest priority
//   memWe            store enable from execute
//   regWe            register-file write enable from execute
//   writeRegFromAlu  1 = write back the ALU result, 0 = write back loaded word
//   regToWrite       destination register index
//   result           ALU result; also the word address for loads and stores
//   dataToWrite      store data
//   stall            hold every register, no RAM write
//   flush            load a bubble, no RAM write (wins over stall)
//   regWeOut         registered regWe
//   regToWriteOut    registered destination index
//   aluResultOut     registered ALU result
//   memDataOut       word read at the registered address (write-first)
//   writeBackData    aluResultOut or memDataOut, chosen by registered select
//   addrFault        sticky: an access targeted an address >= DEPTH
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memWe,
  input  logic              regWe,
  input  logic              writeRegFromAlu,
  input  logic [3:0]        regToWrite,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] dataToWrite,
  input  logic              stall,
  input  logic              flush,
  output logic              regWeOut,
  output logic [3:0]        regToWriteOut,
  output logic [DATA_W-1:0] aluResultOut,
  output logic [DATA_W-1:0] memDataOut,
  output logic [DATA_W-1:0] writeBackData,
  output logic              addrFault
);

  // Range check uses the full ALU result, so high address bits are not
  // silently aliased onto the low RAM words.
  localparam logic [DATA_W-1:0] DEPTH_V = DATA_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              reg_we_q,        reg_we_d;
  logic [3:0]        reg_to_write_q,  reg_to_write_d;
  logic [DATA_W-1:0] alu_result_q,    alu_result_d;
  logic [DATA_W-1:0] mem_data_q,      mem_data_d;
  logic              wr_from_alu_q,   wr_from_alu_d;
  logic              addr_fault_q,    addr_fault_d;

  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              advance;
  logic              store_en;
  logic [DATA_W-1:0] rd_word;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    idx      = result[ADDR_W-1:0];
    in_range = (result < DEPTH_V);
    advance  = !stall && !flush;
    store_en = memWe && in_range && advance && !reset;

    // Write-first: a same-cycle store is what the load sees.
    rd_word = in_range ? mem_q[idx] : '0;
    if (store_en) begin
      rd_word = dataToWrite;
    end

    reg_we_d       = reg_we_q;
    reg_to_write_d = reg_to_write_q;
    alu_result_d   = alu_result_q;
    mem_data_d     = mem_data_q;
    wr_from_alu_d  = wr_from_alu_q;
    addr_fault_d   = addr_fault_q;

    if (flush) begin
      reg_we_d       = 1'b0;
      reg_to_write_d = '0;
      alu_result_d   = '0;
      mem_data_d     = '0;
      wr_from_alu_d  = 1'b1;
    end else if (!stall) begin
      reg_we_d       = regWe;
      reg_to_write_d = regToWrite;
      alu_result_d   = result;
      mem_data_d     = rd_word;
      wr_from_alu_d  = writeRegFromAlu;
      // Only real memory accesses (stores, or loads that write a register)
      // can fault; a pure ALU op with a large result is not an access.
      if ((memWe || !writeRegFromAlu) && (regWe || memWe) && !in_range) begin
        addr_fault_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_we_q       <= 1'b0;
      reg_to_write_q <= '0;
      alu_result_q   <= '0;
      mem_data_q     <= '0;
      wr_from_alu_q  <= 1'b1;
      addr_fault_q   <= 1'b0;
    end else begin
      reg_we_q       <= reg_we_d;
      reg_to_write_q <= reg_to_write_d;
      alu_result_q   <= alu_result_d;
      mem_data_q     <= mem_data_d;
      wr_from_alu_q  <= wr_from_alu_d;
      addr_fault_q   <= addr_fault_d;
    end
  end

  // NOTE: the RAM array has no reset branch; its contents survive reset and
  // it maps onto a block RAM. Reset only suppresses the write via store_en.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem_q[idx] <= dataToWrite;
    end
  end

  assign regWeOut      = reg_we_q;
  assign regToWriteOut = reg_to_write_q;
  assign aluResultOut  = alu_result_q;
  assign memDataOut    = mem_data_q;
  assign writeBackData = wr_from_alu_q ? alu_result_q : mem_data_q;
  assign addrFault     = addr_fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
// Directed stimulus for memory_stage. A behavioural model (plain array plus
// expected output registers) is updated on each rising edge from the same
// inputs the DUT sees; a compare process checks every output against it on
// the falling edge. Literal expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_memory_stage;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              memWe, regWe, writeRegFromAlu;
  logic [3:0]        regToWrite;
  logic [DATA_W-1:0] result, dataToWrite;
  logic              stall, flush;
  logic              regWeOut;
  logic [3:0]        regToWriteOut;
  logic [DATA_W-1:0] aluResultOut, memDataOut, writeBackData;
  logic              addrFault;

  int checks = 0;
  int errors = 0;

  memory_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .memWe(memWe), .regWe(regWe), .writeRegFromAlu(writeRegFromAlu),
    .regToWrite(regToWrite), .result(result), .dataToWrite(dataToWrite),
    .stall(stall), .flush(flush),
    .regWeOut(regWeOut), .regToWriteOut(regToWriteOut),
    .aluResultOut(aluResultOut), .memDataOut(memDataOut),
    .writeBackData(writeBackData), .addrFault(addrFault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_ram [DEPTH];
  logic              m_valid = 1'b0;
  logic              e_reg_we, e_wfa, e_fault;
  logic [3:0]        e_rtw;
  logic [DATA_W-1:0] e_alu, e_mem;

  initial for (int i = 0; i < DEPTH; i++) m_ram[i] = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid  = 1'b1;
      e_reg_we = 1'b0; e_rtw = '0; e_alu = '0; e_mem = '0; e_wfa = 1'b1; e_fault = 1'b0;
    end else if (flush) begin
      e_reg_we = 1'b0; e_rtw = '0; e_alu = '0; e_mem = '0; e_wfa = 1'b1;
    end else if (!stall) begin
      if (int'(result) < DEPTH) begin
        if (memWe) m_ram[int'(result)] = dataToWrite;
        e_mem = m_ram[int'(result)];
      end else begin
        e_mem = '0;
        if ((memWe || !writeRegFromAlu) && (regWe || memWe)) e_fault = 1'b1;
      end
      e_reg_we = regWe; e_rtw = regToWrite; e_alu = result; e_wfa = writeRegFromAlu;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("regWeOut",      32'(regWeOut),      32'(e_reg_we));
      check("regToWriteOut", 32'(regToWriteOut), 32'(e_rtw));
      check("aluResultOut",  32'(aluResultOut),  32'(e_alu));
      check("memDataOut",    32'(memDataOut),    32'(e_mem));
      check("writeBackData", 32'(writeBackData), 32'(e_wfa ? e_alu : e_mem));
      check("addrFault",     32'(addrFault),     32'(e_fault));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic we_m, input logic we_r, input logic wfa,
                       input logic [3:0] rtw, input logic [DATA_W-1:0] addr,
                       input logic [DATA_W-1:0] data);
    memWe = we_m; regWe = we_r; writeRegFromAlu = wfa;
    regToWrite = rtw; result = addr; dataToWrite = data;
  endtask

  // Outputs settle shortly after the edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    stall = 1'b0; flush = 1'b0;

    // 1. reset while a store to address 3 is pending
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 4'd0, 24'd3, 24'h000055);
    tick();
    check("rst_regWeOut", 32'(regWeOut), 32'd0);
    check("rst_regToWriteOut", 32'(regToWriteOut), 32'd0);
    check("rst_aluResultOut", 32'(aluResultOut), 32'd0);
    check("rst_memDataOut", 32'(memDataOut), 32'd0);
    check("rst_writeBackData", 32'(writeBackData), 32'd0);
    check("rst_addrFault", 32'(addrFault), 32'd0);
    reset = 1'b0;

    // 2. store then load
    drive(1'b1, 1'b0, 1'b1, 4'd0, 24'd5, 24'h00ABCD);
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'd2, 24'd5, 24'h000000);
    tick();
    check("ld_memDataOut", 32'(memDataOut), 32'h00ABCD);
    check("ld_writeBackData", 32'(writeBackData), 32'h00ABCD);
    check("ld_regWeOut", 32'(regWeOut), 32'd1);
    check("ld_regToWriteOut", 32'(regToWriteOut), 32'd2);

    // address 3 was not written during reset
    drive(1'b0, 1'b1, 1'b0, 4'd3, 24'd3, 24'h000000);
    tick();
    check("rst_store_dropped", 32'(memDataOut), 32'd0);

    // 3. ALU passthrough
    drive(1'b0, 1'b1, 1'b1, 4'd1, 24'h000007, 24'h000000);
    tick();
    check("alu_aluResultOut", 32'(aluResultOut), 32'd7);
    check("alu_writeBackData", 32'(writeBackData), 32'd7);
    check("alu_regWeOut", 32'(regWeOut), 32'd1);

    // 4. write-first
    drive(1'b1, 1'b0, 1'b1, 4'd0, 24'd9, 24'h000011);
    tick();
    check("wf_memDataOut", 32'(memDataOut), 32'h000011);
    check("wf_writeBackData", 32'(writeBackData), 32'd9);

    // top in-range word
    drive(1'b1, 1'b0, 1'b1, 4'd0, 24'h0000FF, 24'h123456);
    tick();
    check("top_memDataOut", 32'(memDataOut), 32'h123456);
    check("top_addrFault", 32'(addrFault), 32'd0);

    // 5. stall then flush
    drive(1'b0, 1'b1, 1'b1, 4'd6, 24'h000030, 24'h000000);
    tick();
    stall = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'd7, 24'd4, 24'h000022);
    tick();
    check("stl1_regWeOut", 32'(regWeOut), 32'd1);
    check("stl1_aluResultOut", 32'(aluResultOut), 32'h30);
    drive(1'b1, 1'b1, 1'b0, 4'd8, 24'd4, 24'h000022);
    tick();
    check("stl2_regToWriteOut", 32'(regToWriteOut), 32'd6);
    check("stl2_writeBackData", 32'(writeBackData), 32'h30);
    flush = 1'b1;
    tick();
    check("fl_regWeOut", 32'(regWeOut), 32'd0);
    check("fl_writeBackData", 32'(writeBackData), 32'd0);
    stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 4'd5, 24'd4, 24'h000000);
    tick();
    check("stl_store_dropped", 32'(memDataOut), 32'd0);

    // 6. fault: address == DEPTH, then one that aliases onto word 0xFF
    drive(1'b1, 1'b0, 1'b1, 4'd0, 24'h000100, 24'h000077);
    tick();
    check("flt_set", 32'(addrFault), 32'd1);
    check("flt_memDataOut", 32'(memDataOut), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 4'd0, 24'h0100FF, 24'h000999);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'd1, 24'd1, 24'h000000);
      tick();
      check("flt_sticky", 32'(addrFault), 32'd1);
    end
    drive(1'b0, 1'b1, 1'b0, 4'd2, 24'd0, 24'h000000);
    tick();
    check("flt_no_wr_0", 32'(memDataOut), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 4'd2, 24'h0000FF, 24'h000000);
    tick();
    check("flt_no_alias", 32'(memDataOut), 32'h123456);
    reset = 1'b1;
    tick();
    check("flt_cleared", 32'(addrFault), 32'd0);
    reset = 1'b0;

    // RAM keeps its contents across reset
    drive(1'b0, 1'b1, 1'b0, 4'd4, 24'd5, 24'h000000);
    tick();
    check("ram_kept", 32'(writeBackData), 32'h00ABCD);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execution stage, in the 24-bit pipelined core.
- Consumes the execute-stage control bundle (memWe, regWe, writeRegFromAlu, regToWrite), the ALU result used as address, and the store data.
- Owns the word-addressed data RAM, performs loads and stores, and registers the write-back bundle for the write-back stage.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 24, datapath and memory word width.
- ADDR_W, 8, RAM index width; valid word addresses are 0..DEPTH-1.
- DEPTH, 256, number of RAM words; must be <= 2**ADDR_W.

Ports:
- clk  in  1  single core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- memWe  in  1  store enable from execute.
- regWe  in  1  register-file write enable from execute.
- writeRegFromAlu  in  1  1 = write-back ALU result; 0 = write-back loaded word.
- regToWrite  in  4  destination register index.
- result  in  DATA_W  ALU result from execute; memory address on loads/stores.
- dataToWrite  in  DATA_W  store data.
- stall  in  1  hold the stage; no state changes except reset.
- flush  in  1  replace the incoming instruction with a bubble.
- regWeOut  out  1  registered regWe.
- regToWriteOut  out  4  registered destination index.
- aluResultOut  out  DATA_W  registered ALU result.
- memDataOut  out  DATA_W  word read at registered address.
- writeBackData  out  DATA_W  selection: aluResultOut if writeRegFromAlu (registered) else memDataOut.
- addrFault  out  1  sticky flag: an access targeted an address >= DEPTH.

Behaviour:
- Reset, sampled on the rising edge, has priority over everything.
  - Outputs after reset: regWeOut=0, regToWriteOut=0, aluResultOut=0, memDataOut=0, writeBackData=0, addrFault=0.
  - The internal writeRegFromAlu register resets to 1.
  - RAM contents are not cleared by reset; they are zero at time 0 and keep their values across reset.
- Latency: inputs sampled at edge N appear on the outputs immediately after edge N. The stage is exactly one pipeline register deep.
- Address index: idx = result[ADDR_W-1:0]. The access is in range iff result < DEPTH, comparing the full DATA_W value.
- Store:
  - If memWe=1, in range, stall=0, flush=0 and reset=0: RAM[idx] <= dataToWrite on the edge.
  - Out-of-range stores are dropped.
- Load:
  - RAM read is synchronous. memDataOut after edge N = RAM[idx] as it stands after edge N's write (write-first).
  - A store and a read of the same address in one cycle therefore return dataToWrite.
  - Out-of-range reads return 0.
  - memDataOut updates every non-stalled cycle, regardless of writeRegFromAlu.
- addrFault:
  - Sets to 1 when (memWe=1 or writeRegFromAlu=0) with regWe or memWe active, the address is out of range, and the stage is not stalled or flushed.
  - It is cleared only by reset.
- Stall (stall=1, flush=0, reset=0): all output registers hold their values, no RAM write occurs, and addrFault does not update.
- Flush (flush=1, reset=0), which has priority over stall:
  - Loads a bubble: regWeOut=0, regToWriteOut=0, aluResultOut=0, memDataOut=0, writeRegFromAlu register=1.
  - No RAM write occurs.
- Simultaneous stall and flush resolve as flush.
- Reset asserted mid-store: the store is suppressed on that edge.
- writeBackData is combinational from registered state only; it has no path from the stage inputs.
- No handshake with execute. The hazard unit guarantees that stall holds execute's outputs stable.

Test Plan:
1. Reset for 1 cycle with memWe=1, result=3 -> after the edge all outputs are 0, addrFault=0, and RAM[3] stays 0 (verified by a later load).
2. Store then load: cycle A drives memWe=1, result=5, dataToWrite=24'h00ABCD, regWe=0. Cycle B drives memWe=0, regWe=1, writeRegFromAlu=0, regToWrite=2, result=5 -> after B: memDataOut=24'h00ABCD, writeBackData=24'h00ABCD, regWeOut=1, regToWriteOut=2.
3. ALU passthrough: regWe=1, writeRegFromAlu=1, result=24'h000007, regToWrite=1 -> next edge: aluResultOut=7, writeBackData=7, regWeOut=1.
4. Write-first: memWe=1, result=9, dataToWrite=24'h000011 in one cycle -> memDataOut=24'h000011 after that edge.
5. Stall then flush:
   - Hold stall=1 for 2 cycles while the inputs change -> outputs are unchanged and a pending store (memWe=1, result=4, data=24'h000022) is not written.
   - Then flush=1 together with stall=1 -> regWeOut=0, writeBackData=0.
6. Fault: memWe=1, result=24'h000100 (DEPTH=256) -> no RAM write, addrFault=1 and it stays 1 over 3 further clean cycles; reset clears it to 0.
